acc_apb_sequencer: RTL and testbench
====================================

# acc_apb_sequencer

APB master that drives the matrix accelerator slave directly upstream of it. On a start pulse it enables the accelerator, streams A-matrix and X-vector words from a valid/ready source into the accelerator's load registers, then reads result words back from the accelerator RAM and presents them on a valid/ready result stream. Finally it disables the accelerator's clock gate. It replaces software-driven APB traffic so the accelerator can be exercised at full bus rate.

## Interface
Parameters:
- APB_ADDR_WIDTH, 13: width of PADDR.
- A_WORDS, 3: number of 32-bit words written to the A load address per job.
- X_WORDS, 8: number of 32-bit words written to the X load address per job.
- RES_WORDS, 8: number of result words read back per job.
- RES_BASE, 0: first result read address; increments by 1 per word.
- TIMEOUT, 1024: maximum ACCESS cycles without PREADY before the job aborts.

Ports:
- HCLK  in  1  single clock for all logic.
- HRESETn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job request; ignored while busy=1.
- in_data  in  32  A/X word stream, A words first, then X words.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_data  out  32  result word (registered PRDATA).
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- busy  out  1  job in progress (IDLE excluded).
- done  out  1  one-cycle pulse at job end (normal or abort).
- err  out  1  sticky; set on PSLVERR or timeout, cleared on the next accepted start.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE, PSEL, PENABLE  out  1 each  APB controls.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB slave responses.

## Operation
- Phases, in order: EN (write 1 to address 13'h1FFF), LOAD_A (A_WORDS writes to address 1), LOAD_X (X_WORDS writes to address 2), READ (RES_WORDS reads from RES_BASE+i), DIS (write 0 to 13'h1FFF).
- FSM states:
  - IDLE: start → SETUP (EN).
  - WAIT_IN: LOAD_A/LOAD_X only; in_ready=1. On handshake, in_data is latched into PWDATA → SETUP.
  - SETUP: PSEL=1, PENABLE=0 → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1.
  - WAIT_OUT: out_valid=1 until out_ready.
  - DONE: done=1 → IDLE.
- ACCESS with PREADY=1, by phase:
  - Write phases advance the word counter. At phase end, go to the next phase's entry state: WAIT_IN for LOAD_A/LOAD_X, SETUP otherwise. If more words remain, go to WAIT_IN.
  - READ: PRDATA is registered into out_data → WAIT_OUT. After out_ready, go to SETUP with the next address, or to SETUP (DIS) after the last word.
  - DIS → DONE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. Outside SETUP/ACCESS, PSEL=PENABLE=0.
- PSLVERR is sampled only when PREADY=1 in ACCESS. It sets err; the sequence continues.
- Timeout: a counter clears on SETUP entry and increments each ACCESS cycle without PREADY. At TIMEOUT it sets err, drops PSEL/PENABLE, and goes to DONE. The DIS write is skipped. A count of 0 words in any phase skips that phase.

## Timing
- Reset (async, HRESETn=0): state IDLE; every output 0 (PADDR=0, PWDATA=0, out_data=0); counters 0; err=0. Reset mid-transfer drops PSEL the same instant, and the job is lost.
- Zero-wait-state slave, data always available:
  - EN: 2 cycles.
  - Each A/X word: 3 cycles (WAIT_IN, SETUP, ACCESS).
  - Each result word: 3 cycles when out_ready is held high.
  - DIS: 2 cycles.
  - DONE: 1 cycle.
- start is accepted in IDLE only; busy rises the following cycle.
- in_ready is never high outside WAIT_IN. Data stalls extend WAIT_IN indefinitely (not subject to timeout).
- out_valid rises the cycle after the READ ACCESS completes. Consumer backpressure extends WAIT_OUT indefinitely.
- err is updated the cycle after the offending ACCESS. It stays set through done and is cleared on the cycle a new start is accepted.

## Test plan
- Nominal job, A=1,2,3 and X=10..17, zero-wait slave returning PRDATA=100+addr → APB sequence EN, 3×addr1, 8×addr2, 8 reads, DIS. out_data=100..107 in order, done after 2+33+24+2+1 cycles, err=0.
- Slave holds PREADY=0 for 5 cycles on each read → each read lasts 7 cycles, PADDR/PSEL stable throughout, results unchanged.
- Slave never asserts PREADY on the third A write, TIMEOUT=16 → PSEL drops after 16 ACCESS cycles, err=1, done pulse, no DIS write.
- in_valid toggles every other cycle and out_ready is low for 4 cycles per result → no lost or duplicated words, in_ready only in WAIT_IN.
- PSLVERR=1 on the first read → err=1, all 8 reads and DIS still performed. A next start clears err.
- HRESETn pulsed low during an LOAD_X ACCESS → PSEL/PENABLE/busy drop asynchronously. After release, a new start runs a full job correctly.

Source files
------------

// File: rtl/acc_apb_sequencer.sv
// -----------------------------------------------------------------------------
// acc_apb_sequencer
//
// APB master that runs one complete matrix-accelerator job without software.
// On a start pulse it:
//   1. enables the accelerator (write 1 to the control address),
//   2. writes A_WORDS words from the input stream to the A load register,
//   3. writes X_WORDS words from the input stream to the X load register,
//   4. reads RES_WORDS result words (RES_BASE, RES_BASE+1, ...) and offers
//      each one on the result stream,
//   5. disables the accelerator (write 0 to the control address),
// then pulses done. A phase with zero words is skipped.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   start                one-cycle job request, honoured only when idle
//   in_data/valid/ready  A words then X words, valid/ready handshake
//   out_data/valid/ready result words, valid/ready handshake
//   busy                 high whenever the sequencer is not idle
//   done                 one-cycle pulse at job end (normal or aborted)
//   err                  sticky PSLVERR/timeout flag, cleared by next start
//   PADDR..PENABLE       APB master request signals
//   PRDATA/PREADY/PSLVERR APB slave responses
// -----------------------------------------------------------------------------
module acc_apb_sequencer #(
  parameter int APB_ADDR_WIDTH = 13,
  parameter int A_WORDS        = 3,
  parameter int X_WORDS        = 8,
  parameter int RES_WORDS      = 8,
  parameter int RES_BASE       = 0,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      start,
  input  logic [31:0]               in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int CNT_W = 16;
  localparam int TMO_W = 32;

  localparam logic [AW-1:0]    CTRL_ADDR = '1;
  localparam logic [AW-1:0]    A_ADDR    = AW'(1);
  localparam logic [AW-1:0]    X_ADDR    = AW'(2);
  localparam logic [AW-1:0]    RES_ADDR  = AW'(RES_BASE);
  localparam logic [CNT_W-1:0] A_N       = CNT_W'(A_WORDS);
  localparam logic [CNT_W-1:0] X_N       = CNT_W'(X_WORDS);
  localparam logic [CNT_W-1:0] R_N       = CNT_W'(RES_WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_SETUP, S_ACCESS, S_WAIT_OUT, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    P_EN, P_LOAD_A, P_LOAD_X, P_READ, P_DIS
  } phase_e;

  // Next phase after p, skipping any phase that has no words to move.
  function automatic phase_e phase_after(input phase_e p);
    phase_e n;
    n = P_DIS;
    case (p)
      P_EN: begin
        if (A_WORDS > 0)        n = P_LOAD_A;
        else if (X_WORDS > 0)   n = P_LOAD_X;
        else if (RES_WORDS > 0) n = P_READ;
        else                    n = P_DIS;
      end
      P_LOAD_A: begin
        if (X_WORDS > 0)        n = P_LOAD_X;
        else if (RES_WORDS > 0) n = P_READ;
        else                    n = P_DIS;
      end
      P_LOAD_X: begin
        if (RES_WORDS > 0)      n = P_READ;
        else                    n = P_DIS;
      end
      default: n = P_DIS;
    endcase
    return n;
  endfunction

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]      paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               err_q, err_d;

  logic               enter;
  phase_e             enter_phase;
  logic [CNT_W-1:0]   cnt_inc;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;            // only accumulates while sitting in ACCESS
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    enter       = 1'b0;
    enter_phase = P_DIS;
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          phase_d  = P_EN;
          cnt_d    = '0;
          paddr_d  = CTRL_ADDR;
          pwdata_d = 32'd1;
          pwrite_d = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_WAIT_IN: begin
        if (in_valid) begin
          pwdata_d = in_data;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: state_d = S_ACCESS;

      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) err_d = 1'b1;
          case (phase_q)
            P_EN: begin
              enter       = 1'b1;
              enter_phase = phase_after(P_EN);
            end
            P_LOAD_A: begin
              cnt_d = cnt_inc;
              if (cnt_inc == A_N) begin
                enter       = 1'b1;
                enter_phase = phase_after(P_LOAD_A);
              end else begin
                state_d = S_WAIT_IN;
              end
            end
            P_LOAD_X: begin
              cnt_d = cnt_inc;
              if (cnt_inc == X_N) begin
                enter       = 1'b1;
                enter_phase = phase_after(P_LOAD_X);
              end else begin
                state_d = S_WAIT_IN;
              end
            end
            P_READ: begin
              out_data_d = PRDATA;
              state_d    = S_WAIT_OUT;
            end
            default: state_d = S_DONE;   // disable write finished
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Abort: bus released, disable write intentionally not issued.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_WAIT_OUT: begin
        if (out_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == R_N) begin
            enter       = 1'b1;
            enter_phase = phase_after(P_READ);
          end else begin
            paddr_d = paddr_q + AW'(1);
            state_d = S_SETUP;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Phase entry: load the address/direction the new phase will use.
    if (enter) begin
      phase_d = enter_phase;
      cnt_d   = '0;
      case (enter_phase)
        P_LOAD_A: begin
          state_d  = S_WAIT_IN;
          paddr_d  = A_ADDR;
          pwrite_d = 1'b1;
        end
        P_LOAD_X: begin
          state_d  = S_WAIT_IN;
          paddr_d  = X_ADDR;
          pwrite_d = 1'b1;
        end
        P_READ: begin
          state_d  = S_SETUP;
          paddr_d  = RES_ADDR;
          pwrite_d = 1'b0;
          pwdata_d = 32'd0;
        end
        default: begin
          state_d  = S_SETUP;
          paddr_d  = CTRL_ADDR;
          pwrite_d = 1'b1;
          pwdata_d = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      phase_q    <= P_EN;
      cnt_q      <= '0;
      tmo_q      <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  // Bus controls decode straight from the state register so an async
  // reset drops PSEL/PENABLE immediately.
  assign PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign in_ready  = (state_q == S_WAIT_IN);
  assign out_valid = (state_q == S_WAIT_OUT);
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_acc_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acc_apb_sequencer
//
// Directed bench for acc_apb_sequencer (TIMEOUT=16, other parameters default).
// A small APB slave model answers with PRDATA = 100 + PADDR and can insert
// read wait states, hang the third A write, or flag PSLVERR on the first read.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_acc_apb_sequencer;

  localparam int AW = 13;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy, done, err;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  acc_apb_sequencer #(.TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- APB slave model ----------------
  int read_wait   = 0;
  bit hang_mode   = 1'b0;
  bit slverr_mode = 1'b0;
  int acc_cnt     = 0;   // ACCESS cycles already spent without PREADY
  int a_done      = 0;   // A writes completed in the current job

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_cnt <= 0;
      a_done  <= 0;
    end else begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (start) a_done <= 0;
      else if (PSEL && PENABLE && PREADY && PWRITE && PADDR == AW'(1)) a_done <= a_done + 1;
    end
  end

  always_comb begin
    PREADY = 1'b1;
    if (PSEL && PENABLE) begin
      if (!PWRITE && acc_cnt < read_wait) PREADY = 1'b0;
      if (hang_mode && PWRITE && PADDR == AW'(1) && a_done == 2) PREADY = 1'b0;
    end
  end

  assign PRDATA  = 32'd100 + 32'(PADDR);
  assign PSLVERR = slverr_mode && PSEL && PENABLE && !PWRITE && (PADDR == '0);

  // ---------------- checking ----------------
  int n_err = 0;
  int n_chk = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] src_words [11];
  logic [45:0] log_q [$];
  logic [31:0] res_q [$];
  int          busy_cyc, max_run, stab_viol, rdy_viol;
  logic        err_first;

  // Expected APB transfer k of a full job: {PWRITE, PADDR, write data}.
  function automatic logic [45:0] exp_entry(input int k);
    logic [45:0] e;
    if (k == 0)       e = {1'b1, 13'h1FFF, 32'd1};
    else if (k <= 3)  e = {1'b1, 13'd1, 32'(k)};
    else if (k <= 11) e = {1'b1, 13'd2, 32'(10 + k - 4)};
    else if (k <= 19) e = {1'b0, 13'(k - 12), 32'd0};
    else              e = {1'b1, 13'h1FFF, 32'd0};
    return e;
  endfunction

  task automatic check_log(input string tag, input int n);
    check_val({tag, "_log_len"}, 64'(log_q.size()), 64'(n));
    for (int k = 0; k < n && k < log_q.size(); k++)
      check_val($sformatf("%s_apb%0d", tag, k), 64'(log_q[k]), 64'(exp_entry(k)));
  endtask

  task automatic check_res(input string tag);
    check_val({tag, "_res_len"}, 64'(res_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < res_q.size(); k++)
      check_val($sformatf("%s_res%0d", tag, k), 64'(res_q[k]), 64'(100 + k));
  endtask

  // Runs one job; gap_mode toggles in_valid, stall_mode holds out_ready low
  // for 4 cycles per result. Logs every completed APB transfer.
  task automatic run_job(input string tag, input bit gap_mode, input bit stall_mode);
    int          cyc, ov_wait, src_idx, run;
    bit          fin;
    logic [45:0] snap, cur;
    log_q.delete();
    res_q.delete();
    busy_cyc = 0; max_run = 0; stab_viol = 0; rdy_viol = 0; err_first = 1'bx;
    cyc = 0; ov_wait = 0; src_idx = 0; run = 0; fin = 1'b0; snap = '0;
    @(posedge HCLK); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = !stall_mode;
    while (!fin && cyc < 600) begin
      @(negedge HCLK);
      if (cyc == 1) err_first = err;
      if (busy) busy_cyc++;
      if (done) fin = 1'b1;
      if (in_valid && in_ready) src_idx++;
      if (in_ready && (PSEL || out_valid || !busy || done)) rdy_viol++;
      if (out_valid && out_ready) begin
        res_q.push_back(out_data);
        ov_wait = 0;
      end else if (out_valid) begin
        ov_wait++;
      end
      cur = {PWRITE, PADDR, PWRITE ? PWDATA : 32'd0};
      if (PSEL && !PENABLE) snap = cur;
      if (PSEL && PENABLE && cur !== snap) stab_viol++;
      if (PSEL && PENABLE) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (PSEL && PENABLE && PREADY) log_q.push_back(cur);
      @(posedge HCLK); #1;
      start     = 1'b0;
      in_valid  = (src_idx < 11) && (!gap_mode || (cyc % 2 == 1));
      in_data   = src_words[(src_idx < 11) ? src_idx : 10];
      out_ready = stall_mode ? (ov_wait >= 4) : 1'b1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val({tag, "_job_end"}, 64'(fin), 64'd1);
    @(negedge HCLK);
    check_val({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
    $display("job %s: busy_cycles=%0d apb=%0d results=%0d err=%0b", tag, busy_cyc,
             log_q.size(), res_q.size(), err);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 3; i++) src_words[i] = 32'(i + 1);
    for (int i = 0; i < 8; i++) src_words[3 + i] = 32'(10 + i);

    // Reset values while HRESETn is held low.
    #12;
    check_val("rst_psel",     64'(PSEL),      64'd0);
    check_val("rst_penable",  64'(PENABLE),   64'd0);
    check_val("rst_pwrite",   64'(PWRITE),    64'd0);
    check_val("rst_paddr",    64'(PADDR),     64'd0);
    check_val("rst_pwdata",   64'(PWDATA),    64'd0);
    check_val("rst_out_data", 64'(out_data),  64'd0);
    check_val("rst_flags",    64'({busy, done, err, in_ready, out_valid}), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Nominal zero-wait job: 2+33+24+2+1 busy cycles.
    run_job("nom", 1'b0, 1'b0);
    check_log("nom", 21);
    check_res("nom");
    check_val("nom_busy",  64'(busy_cyc),  64'd62);
    check_val("nom_err",   64'(err),       64'd0);
    check_val("nom_stab",  64'(stab_viol), 64'd0);
    check_val("nom_rdy",   64'(rdy_viol),  64'd0);

    // Five wait states on every read: each read SETUP+ACCESS lasts 7 cycles.
    read_wait = 5;
    run_job("wait", 1'b0, 1'b0);
    read_wait = 0;
    check_log("wait", 21);
    check_res("wait");
    check_val("wait_busy", 64'(busy_cyc),  64'd102);
    check_val("wait_run",  64'(max_run),   64'd6);
    check_val("wait_stab", 64'(stab_viol), 64'd0);

    // Third A write never completes: abort after 16 ACCESS cycles, no DIS.
    hang_mode = 1'b1;
    run_job("tmo", 1'b0, 1'b0);
    hang_mode = 1'b0;
    check_log("tmo", 3);
    check_val("tmo_run",  64'(max_run),  64'd16);
    check_val("tmo_err",  64'(err),      64'd1);
    check_val("tmo_busy", 64'(busy_cyc), 64'd27);

    // Input gaps and result backpressure; also clears err left by the abort.
    run_job("gap", 1'b1, 1'b1);
    check_log("gap", 21);
    check_res("gap");
    check_val("gap_err_clr", 64'(err_first), 64'd0);
    check_val("gap_rdy",     64'(rdy_viol),  64'd0);
    check_val("gap_stab",    64'(stab_viol), 64'd0);

    // PSLVERR on the first read: full job still runs, err sticks.
    slverr_mode = 1'b1;
    run_job("slv", 1'b0, 1'b0);
    slverr_mode = 1'b0;
    check_log("slv", 21);
    check_res("slv");
    check_val("slv_err", 64'(err), 64'd1);
    run_job("clr", 1'b0, 1'b0);
    check_val("clr_err_start", 64'(err_first), 64'd0);
    check_val("clr_err_end",   64'(err),       64'd0);

    // Asynchronous reset during an X-write ACCESS.
    @(posedge HCLK); #1;
    start = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE && PADDR == AW'(2)) found = 1'b1;
    end
    check_val("arst_reach", 64'(found), 64'd1);
    #1 HRESETn = 1'b0;
    #1;
    check_val("arst_drop", 64'({PSEL, PENABLE, busy}), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    run_job("post", 1'b0, 1'b0);
    check_log("post", 21);
    check_res("post");
    check_val("post_busy", 64'(busy_cyc), 64'd62);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
